// File: rtl/pump_ctrl_pkg.sv
// Shared types and helpers for the two-pump tank fill controller.
// Contents: FSM state enum, valid thermometer level codes, and a
// decode function mapping a sensor code {S4,S3,S2,S1} to {valid, level}.
package pump_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FILL_LEAD = 2'd1,
      FILL_BOTH = 2'd2,
      FAULT     = 2'd3
   } state_e;

   localparam logic [3:0] LVL_EMPTY = 4'b0000;
   localparam logic [3:0] LVL_1     = 4'b0001;
   localparam logic [3:0] LVL_2     = 4'b0011;
   localparam logic [3:0] LVL_3     = 4'b0111;
   localparam logic [3:0] LVL_FULL  = 4'b1111;

   // Returns {valid, level[2:0]}; non-thermometer codes come back as {0, 0}.
   function automatic logic [3:0] decode_level(input logic [3:0] code);
      logic [3:0] res;
      case (code)
         LVL_EMPTY: res = {1'b1, 3'd0};
         LVL_1:     res = {1'b1, 3'd1};
         LVL_2:     res = {1'b1, 3'd2};
         LVL_3:     res = {1'b1, 3'd3};
         LVL_FULL:  res = {1'b1, 3'd4};
         default:   res = {1'b0, 3'd0};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Level sensor debounce filter.
// Ports:
//   Clock  - system clock, rising edge
//   Reset  - asynchronous active-low reset
//   raw_i  - raw sensor code {S4,S3,S2,S1}
//   filt_o - filtered code; updates once raw_i has been sampled unchanged
//            on DEBOUNCE consecutive edges. Resets to 4'b1111 (full) so
//            nothing pumps until a real low level has been seen.
module sensor_debounce #(
   parameter int DEBOUNCE = 4
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [3:0] raw_i,
   output logic [3:0] filt_o
);

   localparam int CW = $clog2(DEBOUNCE + 1);

   logic [3:0]    sample_q;
   logic [CW-1:0] stab_q, stab_d;
   logic [3:0]    filt_q, filt_d;

   // stab counts edges on which the same code has been seen, including
   // the current one; the reset value of sample_q never counts as a sample.
   always_comb begin
      stab_d = CW'(1);
      if (raw_i == sample_q && stab_q != '0) begin
         stab_d = (stab_q >= CW'(DEBOUNCE)) ? stab_q : stab_q + CW'(1);
      end
      filt_d = (stab_d >= CW'(DEBOUNCE)) ? raw_i : filt_q;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sample_q <= 4'b1111;
         stab_q   <= '0;
         filt_q   <= 4'b1111;
      end else begin
         sample_q <= raw_i;
         stab_q   <= stab_d;
         filt_q   <= filt_d;
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/pump_duty_scheduler.sv
// Lead/lag pump scheduler for the two-pump tank fill system.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | level adequate, both pumps off
// FILL_LEAD | lead pump on, lag pump off
// FILL_BOTH | both pumps on (tank empty)
// FAULT     | invalid code or stalled fill; pumps off until Clear
//
// Ports:
//   Clock, Reset       - system clock; asynchronous active-low reset
//   S1..S4             - level sensors, S1 lowest
//   Clear              - fault acknowledge, only honoured in FAULT with a valid code
//   B1, B2             - pump drives
//   Lead               - 0: B1 leads, 1: B2 leads
//   Fault              - sticky fault indicator
module pump_duty_scheduler #(
   parameter int DEBOUNCE     = 4,
   parameter int MIN_ON       = 8,
   parameter int FILL_TIMEOUT = 1000,
   parameter int CNT_W        = 16
) (
   input  logic Clock,
   input  logic Reset,
   input  logic S1,
   input  logic S2,
   input  logic S3,
   input  logic S4,
   input  logic Clear,
   output logic B1,
   output logic B2,
   output logic Lead,
   output logic Fault
);

   import pump_ctrl_pkg::*;

   logic [3:0]       code_filt;
   logic [3:0]       dec;
   logic             valid;
   logic [2:0]       lvl;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] run_q, run_d;
   logic [CNT_W-1:0] tmo_q, tmo_d;
   logic [2:0]       lvl_prev_q, lvl_prev_d;
   logic             lead_q, lead_d;
   logic             b1_q, b1_d;
   logic             b2_q, b2_d;
   logic             fault_q, fault_d;

   logic             rose, run_done, timed_out, fill_now, fill_next;

   sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
      .Clock  (Clock),
      .Reset  (Reset),
      .raw_i  ({S4, S3, S2, S1}),
      .filt_o (code_filt)
   );

   assign dec   = decode_level(code_filt);
   assign valid = dec[3];
   assign lvl   = dec[2:0];

   always_comb begin
      state_d    = state_q;
      lead_d     = lead_q;
      run_d      = '0;
      tmo_d      = '0;
      lvl_prev_d = valid ? lvl : lvl_prev_q;

      rose      = valid && (lvl > lvl_prev_q);
      run_done  = run_q >= CNT_W'(MIN_ON);
      timed_out = tmo_q >= CNT_W'(FILL_TIMEOUT);

      case (state_q)
         IDLE: begin
            if (!valid)            state_d = FAULT;
            else if (lvl == 3'd0)  state_d = FILL_BOTH;
            else if (lvl == 3'd1)  state_d = FILL_LEAD;
         end
         FILL_LEAD: begin
            if (!valid || timed_out) begin
               state_d = FAULT;
            end else if (lvl == 3'd0) begin
               state_d = FILL_BOTH;
            end else if (lvl == 3'd4 && run_done) begin
               state_d = IDLE;
               lead_d  = ~lead_q;
            end
         end
         FILL_BOTH: begin
            if (!valid || timed_out) begin
               state_d = FAULT;
            end else if (lvl == 3'd4 && run_done) begin
               state_d = IDLE;
               lead_d  = ~lead_q;
            end else if (lvl >= 3'd2) begin
               state_d = FILL_LEAD;
            end
         end
         FAULT: begin
            if (Clear && valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Counters only advance while staying inside the fill states; any
      // entry from IDLE or exit to IDLE/FAULT leaves them at zero.
      fill_now  = (state_q == FILL_LEAD) || (state_q == FILL_BOTH);
      fill_next = (state_d == FILL_LEAD) || (state_d == FILL_BOTH);
      if (fill_now && fill_next) begin
         run_d = run_done ? run_q : run_q + CNT_W'(1);
         if (rose)           tmo_d = '0;
         else if (timed_out) tmo_d = tmo_q;
         else                tmo_d = tmo_q + CNT_W'(1);
      end

      b1_d    = (state_d == FILL_BOTH) || (state_d == FILL_LEAD && !lead_d);
      b2_d    = (state_d == FILL_BOTH) || (state_d == FILL_LEAD &&  lead_d);
      fault_d = (state_d == FAULT);
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         lead_q     <= 1'b0;
         run_q      <= '0;
         tmo_q      <= '0;
         lvl_prev_q <= 3'd4;
         b1_q       <= 1'b0;
         b2_q       <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         lead_q     <= lead_d;
         run_q      <= run_d;
         tmo_q      <= tmo_d;
         lvl_prev_q <= lvl_prev_d;
         b1_q       <= b1_d;
         b2_q       <= b2_d;
         fault_q    <= fault_d;
      end
   end

   assign B1    = b1_q;
   assign B2    = b2_q;
   assign Lead  = lead_q;
   assign Fault = fault_q;

endmodule

// File: doc/pump_duty_scheduler.md
Name: pump_duty_scheduler

Overview:
Lead/lag controller for the two-pump tank fill system. It debounces the four level sensors and decodes them into a tank level. It sequences pumps B1/B2 with hysteresis, a minimum run time and lead alternation between fill cycles. Invalid sensor codes and stalled fills latch a sticky fault that only an explicit Clear can release. It sits between the raw level sensors and the pump drivers.

Parameters:
DEBOUNCE, 4, consecutive identical samples required before a sensor code is accepted (>=1)
MIN_ON, 8, minimum cycles a fill cycle runs before it may stop
FILL_TIMEOUT, 1000, cycles allowed in a fill state without a level rise before a fault is raised
CNT_W, 16, width of the run and timeout counters; must hold max(MIN_ON, FILL_TIMEOUT)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
S1     in  1  level sensor, lowest
S2     in  1  level sensor
S3     in  1  level sensor
S4     in  1  level sensor, highest
Clear  in  1  fault acknowledge; sampled only in FAULT
B1     out 1  pump 1 drive
B2     out 1  pump 2 drive
Lead   out 1  0: B1 is lead pump; 1: B2 is lead pump
Fault  out 1  sticky fault indicator

Behaviour:
- Reset (Reset=0, async): B1=B2=Fault=Lead=0; FSM=IDLE; filtered code=1111 (treated as full, so no pumping at power-up); all counters=0.
- Debounce: raw code {S4,S3,S2,S1} is registered every edge. A code held unchanged for DEBOUNCE consecutive edges becomes the filtered code on the DEBOUNCE-th edge.
- FSM and outputs are registered, so a pump output changes DEBOUNCE+1 edges after the sensor input changes.
- Decode: valid codes are 0000/0001/0011/0111/1111, giving L=0..4. Any other code is invalid (V=0).
- FSM states: IDLE, FILL_LEAD, FILL_BOTH, FAULT. Fault conditions take priority over all other transitions.
- IDLE: B1=B2=0.
  - !V -> FAULT.
  - L==0 -> FILL_BOTH.
  - L==1 -> FILL_LEAD.
  - L=2..4 -> stay.
- FILL_LEAD: the lead pump is on, the lag pump is off.
  - !V or timeout -> FAULT.
  - L==0 -> FILL_BOTH.
  - L==4 && run_cnt>=MIN_ON -> IDLE and toggle Lead.
- FILL_BOTH: both pumps on.
  - !V or timeout -> FAULT.
  - L==4 && run_cnt>=MIN_ON -> IDLE and toggle Lead.
  - L>=2 (not stopping) -> FILL_LEAD; the lag pump turns off with no minimum.
- FAULT: B1=B2=0, Fault=1.
  - Clear=1 && V -> IDLE, Fault=0, Lead unchanged.
  - Clear with an invalid code is ignored.
- run_cnt:
  - Cleared on entry to a fill state from IDLE.
  - Increments every cycle in FILL_LEAD/FILL_BOTH and saturates at MIN_ON.
  - Not cleared on FILL_LEAD<->FILL_BOTH moves.
- Timeout counter:
  - Cleared on fill entry and on any edge where L is greater than the previous L.
  - Otherwise increments in fill states.
  - Reaching FILL_TIMEOUT raises the fault on the next edge.
- Lead toggles only on a normal IDLE return, never on fault or reset.
- Mid-fill reset immediately forces pumps off and Lead=0.

Decomposition:
- Package pump_ctrl_pkg holds:
  - the state enum (IDLE, FILL_LEAD, FILL_BOTH, FAULT);
  - the valid level code constants (LVL_EMPTY=4'b0000 … LVL_FULL=4'b1111);
  - a decode function returning {V, L[2:0]}.
- Sub-module sensor_debounce (parameter DEBOUNCE, 4-bit in/out, Clock/Reset) holds the sample register, the stability counter and the filtered code.

Test Plan:
Bench parameters: DEBOUNCE=2, MIN_ON=4, FILL_TIMEOUT=20.
1. Reset then code 0000 held -> after 3 edges B1=1, B2=1, Fault=0, Lead=0.
2. Ramp 0001, 0011, 0111, 1111 (each held 6 edges) from empty -> B2 drops at 0011, B1 stays on until 1111, then IDLE with Lead=1. A second fill from 0001 -> only B2=1.
3. Code 1010 held 2 edges during FILL_LEAD -> Fault=1, B1=B2=0. Clear=1 while the code is still 1010 -> Fault stays 1. Code 0001 plus Clear -> IDLE, then FILL_LEAD.
4. Glitch of 1 edge from 0111 to 1111 while filling -> ignored (no stop). Stable 1111 reached with run_cnt=2 -> pump holds until run_cnt=4, then stops.
5. 0001 held 22+ edges with no rise -> Fault=1 after FILL_TIMEOUT; Lead unchanged.
6. Reset asserted mid-FILL_BOTH -> B1=B2=0 and Lead=0 asynchronously. After release with filtered code 1111, pumps stay off until a low level is debounced.
